// File: rtl/four_bit_shift_add_multiplier_pkg.sv
// Shared types and sizing constants for the 4x4 shift-add multiplier.
package mult_pkg;

   localparam int OPW   = 4;
   localparam int PW    = 8;
   localparam int STEPS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/four_bit_shift_add_multiplier_rca.sv
// 4-bit ripple-carry adder used for the partial-product accumulation.
module four_bit_RCA_RCS
   import mult_pkg::*;
(
   input  logic [OPW-1:0] a,
   input  logic [OPW-1:0] b,
   input  logic           cin,
   output logic [OPW-1:0] sum,
   output logic           cout
);

   logic [OPW:0] carry;

   assign carry[0] = cin;

   // One full adder per bit, carry rippling from bit 0 upward.
   for (genvar i = 0; i < OPW; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[OPW];

endmodule

// File: rtl/four_bit_shift_add_multiplier.sv
// Sequential 4x4 unsigned multiplier: one add-and-shift step per cycle,
// four steps per product, result latched into P on completion.
module four_bit_shift_add_multiplier
   import mult_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [OPW-1:0] A,
   input  logic [OPW-1:0] B,
   output logic [PW-1:0]  P,
   output logic          busy,
   output logic          done
);

   localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

   state_t         state;
   state_t         state_next;
   logic [OPW-1:0] mcand;
   // The 9-bit working word always has bit 8 clear after the shift, so only
   // the low eight bits need storage.
   logic [PW-1:0]  w;
   logic [1:0]     step_cnt;

   logic [OPW-1:0] addend;
   logic [OPW-1:0] hi_sum;
   logic           add_cout;
   logic [PW-1:0]  w_shifted;

   // Multiplicand is only added in when the current multiplier bit is set.
   assign addend    = w[0] ? mcand : '0;
   assign w_shifted = {add_cout, hi_sum, w[3:1]};

   four_bit_RCA_RCS u_rca (
      .a    (w[7:4]),
      .b    (addend),
      .cin  (1'b0),
      .sum  (hi_sum),
      .cout (add_cout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state selection and status outputs decoded from the current state.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (step_cnt == LAST_STEP) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: operand capture on accept, one shift-add per RUN cycle, and
   // product capture on the final step.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand    <= '0;
         w        <= '0;
         step_cnt <= '0;
         P        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand    <= A;
                  w        <= {4'b0000, B};
                  step_cnt <= '0;
               end
            end
            RUN: begin
               w        <= w_shifted;
               step_cnt <= step_cnt + 2'd1;
               if (step_cnt == LAST_STEP) begin
                  P <= w_shifted;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
